// File: rtl/ksk_pkg.sv
// Shared widths, bank geometry and error-bit positions for the KSK bank writer.
package ksk_pkg;
    localparam int KSK_NUM_IDX = 12;
    localparam int KSK_WORDS   = 512;
    localparam int STAGE_W     = 4;
    localparam int IDX_W       = 4;
    localparam int ADDR_W      = 9;
    localparam int WADDR_W     = ADDR_W + 1;
    localparam int ERR_SEQ     = 0;
    localparam int ERR_IDX     = 1;

    typedef struct packed {
        logic [STAGE_W-1:0] stage;
        logic [IDX_W-1:0]   index;
        logic [ADDR_W-1:0]  addr;
    } tuple_t;

    // Beat order: addr runs fastest, then index, then stage (wraps naturally at 16).
    function automatic tuple_t tuple_next(input tuple_t t, input int num_idx, input int words);
        tuple_t n;
        n = t;
        if (int'(t.addr) == words - 1) begin
            n.addr = '0;
            if (int'(t.index) == num_idx - 1) begin
                n.index = '0;
                n.stage = t.stage + 1'b1;
            end else begin
                n.index = t.index + 1'b1;
            end
        end else begin
            n.addr = t.addr + 1'b1;
        end
        return n;
    endfunction
endpackage

// File: rtl/ksk_bank_writer_if.sv
// KSK beat stream: valid/ready handshake carrying a (stage, index, addr) tag and payload.
interface ksk_bank_writer_if
    import ksk_pkg::*;
#(
    parameter int DATA_W = 64
);
    logic               i_ksk_valid;
    logic               o_ksk_ready;
    logic [STAGE_W-1:0] i_ksk_stage;
    logic [IDX_W-1:0]   i_ksk_index;
    logic [ADDR_W-1:0]  i_ksk_addr;
    logic [DATA_W-1:0]  i_ksk_data;

    modport master (
        output i_ksk_valid, i_ksk_stage, i_ksk_index, i_ksk_addr, i_ksk_data,
        input  o_ksk_ready
    );

    modport slave (
        input  i_ksk_valid, i_ksk_stage, i_ksk_index, i_ksk_addr, i_ksk_data,
        output o_ksk_ready
    );
endinterface

// File: rtl/ksk_pingpong_ctrl.sv
// Two-buffer full/release/stage-tag bookkeeping and the current write-buffer pointer.
// Completion and release take effect on the next cycle; a completion into b wins over a release of b.
module ksk_pingpong_ctrl
    import ksk_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               complete,
    input  logic [STAGE_W-1:0] complete_stage,
    input  logic [1:0]         release_pulse,
    output logic               wr_buf,
    output logic [1:0]         buf_full,
    output logic [STAGE_W-1:0] buf_stage0,
    output logic [STAGE_W-1:0] buf_stage1
);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_buf     <= 1'b0;
            buf_full   <= 2'b00;
            buf_stage0 <= '0;
            buf_stage1 <= '0;
        end else begin
            // Clearing an already-empty buffer is harmless, so no full-qualification needed.
            for (int b = 0; b < 2; b++) begin
                if (release_pulse[b]) begin
                    buf_full[b] <= 1'b0;
                end
            end
            if (complete) begin
                buf_full[wr_buf] <= 1'b1;
                if (wr_buf) begin
                    buf_stage1 <= complete_stage;
                end else begin
                    buf_stage0 <= complete_stage;
                end
                wr_buf <= ~wr_buf;
            end
        end
    end
endmodule

// File: rtl/ksk_bank_writer.sv
// Decodes KSK beats into one-hot bank writes (1-cycle latency) into a ping-pong buffer pair.
// Ready drops while the current write buffer is full and awaiting release by the consumer.
module ksk_bank_writer
    import ksk_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int NUM_IDX = KSK_NUM_IDX,
    parameter int WORDS   = KSK_WORDS
)(
    input  logic               clk,
    input  logic               rst,
    ksk_bank_writer_if.slave   ksk,
    output logic [NUM_IDX-1:0] o_bank_we,
    output logic [WADDR_W-1:0] o_bank_waddr,
    output logic [DATA_W-1:0]  o_bank_wdata,
    output logic [1:0]         o_buf_full,
    output logic [STAGE_W-1:0] o_buf_stage0,
    output logic [STAGE_W-1:0] o_buf_stage1,
    input  logic [1:0]         i_buf_release,
    output logic [1:0]         o_err
);
    logic   wr_buf;
    logic   accept;
    logic   legal;
    logic   last_beat;
    tuple_t beat;
    tuple_t expected;

    assign ksk.o_ksk_ready = !o_buf_full[wr_buf] && !rst;
    assign accept          = ksk.i_ksk_valid && ksk.o_ksk_ready;
    assign legal           = {{(32-IDX_W){1'b0}}, ksk.i_ksk_index} < 32'(NUM_IDX);
    assign beat            = '{stage: ksk.i_ksk_stage, index: ksk.i_ksk_index, addr: ksk.i_ksk_addr};
    assign last_beat       = accept && legal
                             && (beat.index == IDX_W'(NUM_IDX - 1))
                             && (beat.addr == ADDR_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            o_bank_we    <= '0;
            o_bank_waddr <= '0;
            o_bank_wdata <= '0;
            o_err        <= 2'b00;
            expected     <= '0;
        end else begin
            o_bank_we <= '0;
            if (accept && legal) begin
                o_bank_we    <= NUM_IDX'(1) << beat.index;
                o_bank_waddr <= {wr_buf, beat.addr};
                o_bank_wdata <= ksk.i_ksk_data;
                if (beat != expected) begin
                    o_err[ERR_SEQ] <= 1'b1;
                end
                // Resync on every legal beat; on a match this is just the normal advance.
                expected <= tuple_next(beat, NUM_IDX, WORDS);
            end
            if (accept && !legal) begin
                o_err[ERR_IDX] <= 1'b1;
            end
        end
    end

    ksk_pingpong_ctrl u_pingpong (
        .clk            (clk),
        .rst            (rst),
        .complete       (last_beat),
        .complete_stage (beat.stage),
        .release_pulse  (i_buf_release),
        .wr_buf         (wr_buf),
        .buf_full       (o_buf_full),
        .buf_stage0     (o_buf_stage0),
        .buf_stage1     (o_buf_stage1)
    );
endmodule

// File: tb/tb_ksk_bank_writer.sv
// Scoreboarded bench: a positional reference model predicts bank writes and buffer/error state.
module tb_ksk_bank_writer;
    localparam int BEATS_PER_STAGE = 6144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bank_we;
    logic [9:0]  bank_waddr;
    logic [63:0] bank_wdata;
    logic [1:0]  buf_full;
    logic [3:0]  buf_stage0;
    logic [3:0]  buf_stage1;
    logic [1:0]  buf_release = 2'b00;
    logic [1:0]  err;

    ksk_bank_writer_if #(.DATA_W(64)) ksk ();

    ksk_bank_writer #(.DATA_W(64), .NUM_IDX(12), .WORDS(512)) dut (
        .clk           (clk),
        .rst           (rst),
        .ksk           (ksk),
        .o_bank_we     (bank_we),
        .o_bank_waddr  (bank_waddr),
        .o_bank_wdata  (bank_wdata),
        .o_buf_full    (buf_full),
        .o_buf_stage0  (buf_stage0),
        .o_buf_stage1  (buf_stage1),
        .i_buf_release (buf_release),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model: stream position = stage*6144 + index*512 + addr.
    int          m_exp;
    logic [1:0]  m_full;
    logic [3:0]  m_stage[2];
    int          m_wbuf;
    logic [1:0]  m_err;

    function automatic int pos_stage(input int p); return (p / BEATS_PER_STAGE) % 16; endfunction
    function automatic int pos_idx(input int p);   return (p / 512) % 12;             endfunction
    function automatic int pos_addr(input int p);  return p % 512;                    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_full"},   buf_full,   m_full);
        check({tag, "_stage0"}, buf_stage0, m_stage[0]);
        check({tag, "_stage1"}, buf_stage1, m_stage[1]);
        check({tag, "_err"},    err,        m_err);
    endtask

    task automatic model_clear();
        m_exp      = 0;
        m_full     = 2'b00;
        m_stage[0] = 4'd0;
        m_stage[1] = 4'd0;
        m_wbuf     = 0;
        m_err      = 2'b00;
    endtask

    task automatic model_beat(input int st, input int ix, input int ad, input logic [63:0] d, output bit cmp);
        wr_t e;
        int  p;
        cmp = 1'b0;
        if (ix > 11) begin
            m_err[1] = 1'b1;
            return;
        end
        e.due   = cyc + 1;
        e.we    = 12'd1 << ix;
        e.waddr = (m_wbuf * 512) + ad;
        e.wdata = d;
        sb_q.push_back(e);
        p = st * BEATS_PER_STAGE + ix * 512 + ad;
        if (p != m_exp) m_err[0] = 1'b1;
        m_exp = (p + 1) % (16 * BEATS_PER_STAGE);
        cmp = (ix == 11 && ad == 511);
    endtask

    // Called at a falling edge; presents one cycle of stimulus and returns at the next falling edge.
    task automatic drive(input bit v, input int st, input int ix, input int ad,
                         input logic [63:0] d, input logic [1:0] rl, output bit acc);
        bit mready;
        bit cmp;
        ksk.i_ksk_valid = v;
        ksk.i_ksk_stage = 4'(st);
        ksk.i_ksk_index = 4'(ix);
        ksk.i_ksk_addr  = 9'(ad);
        ksk.i_ksk_data  = d;
        buf_release     = rl;
        #1;
        mready = !rst && !m_full[m_wbuf];
        check("ready", ksk.o_ksk_ready, mready);
        acc = v && mready;
        cmp = 1'b0;
        if (acc) model_beat(st, ix, ad, d, cmp);
        for (int b = 0; b < 2; b++) if (rl[b]) m_full[b] = 1'b0;
        if (cmp) begin
            m_full[m_wbuf]  = 1'b1;
            m_stage[m_wbuf] = 4'(st);
            m_wbuf          = 1 - m_wbuf;
        end
        @(negedge clk);
        buf_release = 2'b00;
    endtask

    task automatic stream(input int start, input int count, input int gap_pct, input logic [1:0] rel_last);
        int          p;
        int          n;
        int          stall;
        bit          v;
        bit          acc;
        logic [1:0]  rl;
        p = start; n = 0; stall = 0;
        while (n < count) begin
            v  = ($urandom_range(99) >= gap_pct);
            rl = (v && n == count - 1) ? rel_last : 2'b00;
            drive(v, pos_stage(p), pos_idx(p), pos_addr(p), {$urandom, $urandom}, rl, acc);
            if (acc) begin
                p++; n++; stall = 0;
            end else if (++stall > 200) begin
                n_checks++; n_fail++;
                $display("FAIL stream_stall: got no acceptance in 200 cycles, required progress at pos %0d", p);
                return;
            end
        end
    endtask

    task automatic do_reset(input bit keep_valid);
        if (!keep_valid) ksk.i_ksk_valid = 1'b0;
        buf_release = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        check("rst_we",     bank_we,         0);
        check("rst_waddr",  bank_waddr,      0);
        check("rst_wdata",  bank_wdata,      0);
        check("rst_full",   buf_full,        0);
        check("rst_stage0", buf_stage0,      0);
        check("rst_stage1", buf_stage1,      0);
        check("rst_err",    err,             0);
        check("rst_ready",  ksk.o_ksk_ready, 0);
        rst = 1'b0;
        ksk.i_ksk_valid = 1'b0;
    endtask

    // Monitor: a write is required exactly in the cycle the scoreboard says it is due.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                check("bank_we",    bank_we,    e.we);
                check("bank_waddr", bank_waddr, e.waddr);
                check("bank_wdata", bank_wdata, e.wdata);
            end else begin
                check("bank_we_idle", bank_we, 0);
            end
        end
    end

    initial begin
        bit acc;
        int r, st, ix, ad;
        logic [1:0] rl;
        ksk.i_ksk_valid = 1'b0;
        ksk.i_ksk_stage = '0;
        ksk.i_ksk_index = '0;
        ksk.i_ksk_addr  = '0;
        ksk.i_ksk_data  = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset(1'b0);

        // One full stage, valid held high.
        stream(0, BEATS_PER_STAGE, 0, 2'b00);
        check_state("s0");
        check("s0_full_const", buf_full, 2'b01);
        check("s0_err_const",  err,      2'b00);

        // Second stage fills buffer 1; stall until buffer 0 is released.
        stream(BEATS_PER_STAGE, BEATS_PER_STAGE, 0, 2'b00);
        check("s1_full_const",  buf_full,        2'b11);
        check("s1_ready_const", ksk.o_ksk_ready, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 2, 0, 0, {$urandom, $urandom}, 2'b00, acc);
        drive(1'b0, 0, 0, 0, 64'd0, 2'b01, acc);
        check("rel_ready_const", ksk.o_ksk_ready, 1'b1);
        stream(2 * BEATS_PER_STAGE, 20, 0, 2'b00);
        check_state("s2");

        // Completion into buffer 1 coincident with release of buffer 0.
        do_reset(1'b0);
        stream(0, BEATS_PER_STAGE, 20, 2'b00);
        stream(BEATS_PER_STAGE, BEATS_PER_STAGE, 20, 2'b01);
        check("coinc_full_const", buf_full, 2'b10);
        check_state("coinc");

        // Illegal index, then a skipped address, within one stage.
        do_reset(1'b0);
        stream(0, 5, 0, 2'b00);
        drive(1'b1, 0, 13, 5, {$urandom, $urandom}, 2'b00, acc);
        check("illegal_err_const", err, 2'b10);
        stream(5, 2 * 512 + 100 - 5, 0, 2'b00);
        stream(2 * 512 + 101, BEATS_PER_STAGE - (2 * 512 + 101), 0, 2'b00);
        check("skip_err_const",  err,      2'b11);
        check("skip_full_const", buf_full, 2'b01);
        check_state("skip");

        // Reset mid-stage with a beat on the bus, then a clean fresh stage.
        do_reset(1'b0);
        stream(0, 3000, 0, 2'b00);
        ksk.i_ksk_valid = 1'b1;
        ksk.i_ksk_stage = 4'(pos_stage(3000));
        ksk.i_ksk_index = 4'(pos_idx(3000));
        ksk.i_ksk_addr  = 9'(pos_addr(3000));
        ksk.i_ksk_data  = {$urandom, $urandom};
        do_reset(1'b1);
        stream(0, BEATS_PER_STAGE, 10, 2'b00);
        check("mid_rst_full_const", buf_full, 2'b01);
        check("mid_rst_err_const",  err,      2'b00);

        // Randomized mix of in-order, illegal and arbitrary beats with random releases.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            if (r < 60) begin
                st = pos_stage(m_exp); ix = pos_idx(m_exp); ad = pos_addr(m_exp);
            end else if (r < 70) begin
                st = $urandom_range(15); ix = $urandom_range(15, 12); ad = $urandom_range(511);
            end else begin
                st = $urandom_range(15);
                ix = ($urandom_range(2) == 0) ? 11 : $urandom_range(11);
                ad = ($urandom_range(2) == 0) ? 511 : $urandom_range(511);
            end
            rl = {($urandom_range(9) == 0), ($urandom_range(9) == 0)};
            drive($urandom_range(3) != 0, st, ix, ad, {$urandom, $urandom}, rl, acc);
            if (i % 100 == 99) check_state("fuzz");
        end

        repeat (3) drive(1'b0, 0, 0, 0, 64'd0, 2'b00, acc);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
